mac_operand_scatter: RTL and testbench

Front-end operand distributor for the 1D convolution datapath. It is the scatter side of the 8-lane MAC array, sitting opposite the pipelined saturating adder tree that gathers the lanes. It takes a stream of 14-bit signed samples, keeps a sliding window of N_TAPS samples, and issues window × weight operand pairs to the 8 lanes over N_TAPS/8 beats. It drives MAC enable/clear and pulses the capture strobe once the tree output is valid.

---
 rtl/conv_pkg.sv | 16 +
 rtl/weight_regfile.sv | 40 ++++
 rtl/mac_operand_scatter.sv | 136 +++++++++++++
 tb/tb_mac_operand_scatter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 1D convolution datapath.
package conv_pkg;
   localparam int DATA_W = 14;
   localparam int ACC_W  = 28;
   localparam int LANES  = 8;

   typedef logic signed [DATA_W-1:0] data_t;

   typedef enum logic [2:0] {
      S_FILL,
      S_ISSUE,
      S_DRAIN,
      S_CAPTURE,
      S_SLIDE
   } scatter_state_t;
endpackage

// File: rtl/weight_regfile.sv
// Kernel weight store: one write port, LANES read ports addressed by beat.
// Writes are refused while the lock input is high.
module weight_regfile
   import conv_pkg::*;
#(
   parameter int N_TAPS = 16,
   parameter int BEAT_W = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      we,
   input  logic                      lock,
   input  logic [$clog2(N_TAPS)-1:0] addr,
   input  data_t                     wdata,
   input  logic [BEAT_W-1:0]         rd_beat,
   output data_t [LANES-1:0]         rd_data
);
   localparam int ADDR_W = $clog2(N_TAPS);

   data_t r_w [N_TAPS];
   logic  w_wr;

   assign w_wr = we & ~lock;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_w <= '{default: '0};
      end else if (w_wr) begin
         r_w[addr] <= wdata;
      end
   end

   // A write landing on the same edge that loads beat 0 is forwarded, so the
   // new weight is already visible in the following cycle.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_idx;
      assign w_idx       = ADDR_W'(rd_beat * LANES + gi);
      assign rd_data[gi] = (w_wr && addr == w_idx) ? wdata : r_w[w_idx];
   end
endmodule

// File: rtl/mac_operand_scatter.sv
// Sliding-window operand distributor for the 8-lane MAC array: holds N_TAPS
// samples and issues window x weight pairs over N_TAPS/8 beats.
module mac_operand_scatter
   import conv_pkg::*;
#(
   parameter int N_TAPS   = 16,
   parameter int TREE_LAT = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  data_t                     in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      flush,
   input  logic                      w_we,
   input  logic [$clog2(N_TAPS)-1:0] w_addr,
   input  data_t                     w_data,
   output logic                      w_err,
   output data_t [LANES-1:0]         lane_a,
   output data_t [LANES-1:0]         lane_b,
   output logic                      mac_en,
   output logic                      mac_clear,
   output logic                      sum_capture
);
   localparam int BEATS  = N_TAPS / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CNT_W  = $clog2(N_TAPS);
   localparam int DRN_W  = (TREE_LAT > 1) ? $clog2(TREE_LAT) : 1;

   scatter_state_t    r_state, w_state_next;
   logic [CNT_W-1:0]  r_fill_cnt;
   logic [BEAT_W-1:0] r_beat, w_beat_next;
   logic [DRN_W-1:0]  r_drain_cnt;
   data_t             r_window [N_TAPS];
   data_t             w_window_next [N_TAPS];
   data_t [LANES-1:0] w_a_sel;
   data_t [LANES-1:0] w_b_sel;
   logic              w_accept;
   logic              w_lock;

   assign in_ready = ~reset & (r_state == S_FILL || r_state == S_SLIDE);
   assign w_accept = in_valid & in_ready;
   assign w_lock   = (r_state == S_ISSUE) || (r_state == S_DRAIN);

   // window[0] is the oldest sample; new samples enter at the top.
   for (genvar gi = 0; gi < N_TAPS - 1; gi++) begin : g_shift
      assign w_window_next[gi] = w_accept ? r_window[gi+1] : r_window[gi];
   end
   assign w_window_next[N_TAPS-1] = w_accept ? in_data : r_window[N_TAPS-1];

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [CNT_W-1:0] w_idx;
      assign w_idx       = CNT_W'(w_beat_next * LANES + gi);
      assign w_a_sel[gi] = w_window_next[w_idx];
   end

   weight_regfile #(
      .N_TAPS (N_TAPS),
      .BEAT_W (BEAT_W)
   ) u_weights (
      .clk     (clk),
      .reset   (reset),
      .we      (w_we),
      .lock    (w_lock),
      .addr    (w_addr),
      .wdata   (w_data),
      .rd_beat (w_beat_next),
      .rd_data (w_b_sel)
   );

   always_comb begin
      w_state_next = r_state;
      w_beat_next  = r_beat;
      case (r_state)
         S_FILL: begin
            if (w_accept && r_fill_cnt == CNT_W'(N_TAPS - 1)) begin
               w_state_next = S_ISSUE;
               w_beat_next  = '0;
            end
         end
         S_ISSUE: begin
            if (r_beat == BEAT_W'(BEATS - 1)) w_state_next = S_DRAIN;
            else                              w_beat_next  = r_beat + 1'b1;
         end
         S_DRAIN: begin
            if (r_drain_cnt == DRN_W'(TREE_LAT - 1)) w_state_next = S_CAPTURE;
         end
         S_CAPTURE: w_state_next = S_SLIDE;
         S_SLIDE: begin
            if (w_accept) begin
               w_state_next = S_ISSUE;
               w_beat_next  = '0;
            end
         end
         default: w_state_next = S_FILL;
      endcase
      if (flush) w_state_next = S_FILL;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) r_window <= '{default: '0};
      else                r_window <= w_window_next;
   end

   // Operand and strobe registers are loaded from next-state values so each
   // beat appears in the cycle right after the edge that selects it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_FILL;
         r_beat      <= '0;
         r_fill_cnt  <= '0;
         r_drain_cnt <= '0;
         lane_a      <= '0;
         lane_b      <= '0;
         mac_en      <= 1'b0;
         mac_clear   <= 1'b0;
         sum_capture <= 1'b0;
         w_err       <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_beat  <= w_beat_next;
         if (flush || w_state_next != S_FILL) r_fill_cnt <= '0;
         else if (w_accept)                   r_fill_cnt <= r_fill_cnt + 1'b1;
         if (r_state == S_DRAIN && w_state_next == S_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
         else                                               r_drain_cnt <= '0;
         if (w_state_next == S_ISSUE) begin
            lane_a <= w_a_sel;
            lane_b <= w_b_sel;
         end
         mac_en      <= (w_state_next == S_ISSUE);
         mac_clear   <= (w_state_next == S_ISSUE) && (r_state != S_ISSUE);
         sum_capture <= (w_state_next == S_CAPTURE);
         w_err       <= w_we & w_lock;
      end
   end
endmodule

// File: tb/tb_mac_operand_scatter.sv
// Directed bench for mac_operand_scatter: timeline model of windows and
// weights checked every cycle, plus literal spot checks of key beats.
module tb_mac_operand_scatter;
   import conv_pkg::*;

   localparam int N     = 16;
   localparam int TL    = 5;
   localparam int NL    = 8;
   localparam int BEATS = N / NL;

   typedef data_t [NL-1:0] lanes_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   data_t         in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          flush = 1'b0;
   logic          w_we = 1'b0;
   logic [3:0]    w_addr = '0;
   data_t         w_data = '0;
   logic          w_err;
   lanes_t        lane_a, lane_b;
   logic          mac_en, mac_clear, sum_capture;

   int n_checks = 0;
   int n_fail   = 0;

   mac_operand_scatter #(.N_TAPS(N), .TREE_LAT(TL)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .flush       (flush),
      .w_we        (w_we),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .w_err       (w_err),
      .lane_a      (lane_a),
      .lane_b      (lane_b),
      .mac_en      (mac_en),
      .mac_clear   (mac_clear),
      .sum_capture (sum_capture)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [111:0] act, input logic [111:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Keeps the accepted samples as a queue and places every completed window
   // on a timeline: beats, drain, capture, then ready again.
   data_t  m_win[$];
   data_t  m_snap [N];
   data_t  m_w [N];
   int     edge_n = 0;
   int     m_t = -1;
   int     m_p;
   bit     m_live = 0;
   bit     m_locked;
   lanes_t e_a = '0, e_b = '0;
   logic   e_en = 0, e_clr = 0, e_cap = 0, e_err = 0, e_ready = 0;

   always @(posedge clk) begin
      edge_n++;
      if (reset) begin
         m_win.delete();
         foreach (m_w[j]) m_w[j] = '0;
         m_t = -1;
         e_a = '0; e_b = '0;
         e_en = 0; e_clr = 0; e_cap = 0; e_err = 0;
         e_ready = 1;
         m_live = 1;
      end else if (m_live) begin
         m_p      = edge_n - 1 - m_t;
         m_locked = (m_t >= 0) && (m_p >= 0) && (m_p < BEATS + TL);
         e_err    = w_we && m_locked;
         if (w_we && !m_locked) m_w[w_addr] = w_data;
         if (flush) begin
            m_win.delete();
            m_t = -1;
         end else if (e_ready && in_valid) begin
            m_win.push_back(in_data);
            if (m_win.size() > N) void'(m_win.pop_front());
            if (m_win.size() == N) begin
               m_t = edge_n;
               foreach (m_snap[j]) m_snap[j] = m_win[j];
            end
         end
         m_p   = edge_n - m_t;
         e_en  = (m_t >= 0) && (m_p < BEATS);
         e_clr = e_en && (m_p == 0);
         if (e_en) begin
            for (int i = 0; i < NL; i++) begin
               e_a[i] = m_snap[NL*m_p + i];
               e_b[i] = m_w[NL*m_p + i];
            end
         end
         e_cap   = (m_t >= 0) && (m_p == BEATS + TL);
         e_ready = !((m_t >= 0) && (m_p <= BEATS + TL));
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("in_ready", in_ready, e_ready && !reset);
         chk("mac_en", mac_en, e_en);
         chk("mac_clear", mac_clear, e_clr);
         chk("sum_capture", sum_capture, e_cap);
         chk("w_err", w_err, e_err);
         chk("lane_a", lane_a, e_a);
         chk("lane_b", lane_b, e_b);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input data_t v);
      int n = 0;
      in_valid = 1'b1;
      in_data  = v;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout at %0t: in_ready got 0 required 1", $time);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_ready_timeout at %0t: in_ready got 0 required 1", $time);
      end
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   function automatic lanes_t ramp(input int base);
      lanes_t r;
      for (int i = 0; i < NL; i++) r[i] = data_t'(base + i);
      return r;
   endfunction

   function automatic lanes_t all_of(input data_t v);
      lanes_t r;
      for (int i = 0; i < NL; i++) r[i] = v;
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog at %0t: simulation did not complete", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk("rst_lane_a", lane_a, '0);
      chk("rst_mac_en", mac_en, 0);
      chk("rst_in_ready", in_ready, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      for (int j = 0; j < N; j++) begin
         w_we = 1'b1; w_addr = 4'(j); w_data = 14'sd1;
         tick();
      end
      w_we = 1'b0;

      // Basic contiguous window
      for (int v = 1; v <= N; v++) send(data_t'(v));
      chk("basic_b0_lane_a", lane_a, ramp(1));
      chk("basic_b0_clear", mac_clear, 1);
      chk("basic_b0_lane_b", lane_b, all_of(14'sd1));
      tick();
      chk("basic_b1_lane_a", lane_a, ramp(9));
      chk("basic_b1_clear", mac_clear, 0);
      chk("basic_b1_en", mac_en, 1);
      for (int n = 0; n < TL; n++) begin
         tick();
         chk("basic_no_cap", sum_capture, 0);
         chk("basic_busy_ready", in_ready, 0);
      end
      tick();
      chk("basic_cap", sum_capture, 1);
      chk("cap_ready", in_ready, 0);

      // Slide by one, with a write attempted while issuing
      send(14'sd17);
      chk("slide_b0_lane_a", lane_a, ramp(2));
      w_we = 1'b1; w_addr = 4'd3; w_data = -14'sd5;
      tick();
      w_we = 1'b0;
      chk("lock_w_err", w_err, 1);
      chk("slide_b1_lane_a", lane_a, ramp(10));
      wait_ready();
      send(14'sd18);
      chk("lock_w3_unchanged", lane_b[3], 14'sd1);
      chk("slide2_b0_lane_a", lane_a, ramp(3));
      wait_ready();
      w_we = 1'b1; w_addr = 4'd3; w_data = -14'sd5;
      tick();
      w_we = 1'b0;
      chk("slide_w_err", w_err, 0);
      send(14'sd19);
      chk("slide_w3_new", lane_b[3], -14'sd5);
      chk("slide_w2_keep", lane_b[2], 14'sd1);
      chk("slide3_b0_lane_a", lane_a, ramp(4));

      // Fill with random gaps
      wait_ready();
      do_flush();
      for (int v = 100; v < 100 + N; v++) begin
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
         send(data_t'(v));
         if (v < 100 + N - 1) chk("gap_no_mac_en", mac_en, 0);
      end
      chk("gap_b0_lane_a", lane_a, ramp(100));
      chk("gap_b0_clear", mac_clear, 1);

      // Flush during drain
      tick();
      tick();
      do_flush();
      chk("flush_ready", in_ready, 1);
      chk("flush_mac_en", mac_en, 0);
      repeat (TL + 3) begin
         tick();
         chk("flush_no_cap", sum_capture, 0);
      end
      for (int v = 200; v < 200 + N - 1; v++) begin
         send(data_t'(v));
         chk("refill_no_mac_en", mac_en, 0);
      end
      send(data_t'(200 + N - 1));
      chk("refill_mac_en", mac_en, 1);
      chk("refill_lane_a", lane_a, ramp(200));

      // Extreme values, then reset in the middle of issuing
      wait_ready();
      do_flush();
      for (int j = 0; j < NL; j++) send(14'h2000);
      for (int j = 0; j < NL; j++) send(14'h1fff);
      chk("ext_min", lane_a, all_of(14'h2000));
      chk("ext_min_sign", lane_a[7][13], 1);
      tick();
      chk("ext_max", lane_a, all_of(14'h1fff));
      chk("ext_max_sign", lane_a[0][13], 0);
      reset = 1'b1;
      tick();
      chk("midrst_lane_a", lane_a, '0);
      chk("midrst_lane_b", lane_b, '0);
      chk("midrst_mac_en", mac_en, 0);
      reset = 1'b0;
      for (int v = 1; v <= N; v++) send(data_t'(v));
      chk("postrst_lane_b", lane_b, '0);
      chk("postrst_lane_a", lane_a, ramp(1));
      wait_ready();
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
